seg7_capture: RTL

// - Reads back active-low seven-segment patterns, the same encoding the lab blocks drive onto HEX0-HEX5.
// - Decodes each pattern to a hex nibble and accumulates up to DIGITS nibbles into one value.
// - Presents the value on a valid/ready handshake.
// - Used as a loopback checker behind display encoders, and to capture HEX traffic on the board.

---
 rtl/seg7_capture.sv | 109 ++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// Captures active-low seven-segment patterns, debounces them, decodes to hex
// nibbles and assembles DIGITS nibbles into a word offered on a valid/ready port.
module seg7_capture #(
  parameter int DIGITS        = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [6:0]            seg_n,
  input  logic                  seg_strobe,
  input  logic                  flush,
  output logic [4*DIGITS-1:0]   out_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            digit_count,
  output logic                  busy,
  output logic                  err_invalid,
  input  logic                  err_clear
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, DECODE, PRESENT} state_t;

  state_t        state;
  logic [6:0]    sample;
  logic [CW-1:0] cnt;
  logic [4:0]    dec;

  // {hit, nibble}; anything outside the table (blank included) is a miss
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h40: return 5'h10;  7'h79: return 5'h11;
      7'h24: return 5'h12;  7'h30: return 5'h13;
      7'h19: return 5'h14;  7'h12: return 5'h15;
      7'h02: return 5'h16;  7'h78: return 5'h17;
      7'h00: return 5'h18;  7'h10: return 5'h19;
      7'h08: return 5'h1A;  7'h03: return 5'h1B;
      7'h46: return 5'h1C;  7'h21: return 5'h1D;
      7'h06: return 5'h1E;  7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign dec  = seg_decode(sample);
  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      sample      <= '0;
      cnt         <= '0;
      out_value   <= '0;
      out_valid   <= 1'b0;
      digit_count <= '0;
      err_invalid <= 1'b0;
    end else begin
      if (err_clear) err_invalid <= 1'b0;
      case (state)
        IDLE: begin
          // flush takes priority; a coincident strobe is simply dropped
          if (flush && digit_count != 3'd0) begin
            out_valid <= 1'b1;
            state     <= PRESENT;
          end else if (seg_strobe) begin
            sample <= seg_n;
            cnt    <= '0;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (seg_n != sample) begin
            sample <= seg_n;
            cnt    <= '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            state <= DECODE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DECODE: begin
          if (dec[4]) begin
            out_value   <= (out_value << 4) | (4*DIGITS)'(dec[3:0]);
            digit_count <= digit_count + 3'd1;
            if (int'(digit_count) + 1 == DIGITS) begin
              out_valid <= 1'b1;
              state     <= PRESENT;
            end else begin
              state <= IDLE;
            end
          end else begin
            err_invalid <= 1'b1;
            state       <= IDLE;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_value   <= '0;
            digit_count <= '0;
            out_valid   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
